// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds dispatched instructions until both operands are ready,
// exposes a request vector to the select encoder and moves the granted entry into an issue slot.
module issue_queue #(
    parameter int DEPTH     = 8,
    parameter int IDX_W     = $clog2(DEPTH),
    parameter int TAG_W     = 6,
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_disp_valid,
    output logic                 o_disp_ready,
    input  logic [PAYLOAD_W-1:0] i_disp_payload,
    input  logic [TAG_W-1:0]     i_disp_dst_tag,
    input  logic [TAG_W-1:0]     i_disp_src1_tag,
    input  logic [TAG_W-1:0]     i_disp_src2_tag,
    input  logic                 i_disp_src1_rdy,
    input  logic                 i_disp_src2_rdy,
    input  logic                 i_wb_valid,
    input  logic [TAG_W-1:0]     i_wb_tag,
    output logic [DEPTH-1:0]     o_req_vec,
    input  logic                 i_grant_valid,
    input  logic [IDX_W-1:0]     i_grant_idx,
    output logic                 o_iss_valid,
    input  logic                 i_iss_ready,
    output logic [PAYLOAD_W-1:0] o_iss_payload,
    output logic [TAG_W-1:0]     o_iss_dst_tag,
    output logic [IDX_W:0]       o_count
);

    localparam logic [0:0]     S_EMPTY    = 1'b0;
    localparam logic [0:0]     S_FULL     = 1'b1;
    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_rdy1;
    logic [DEPTH-1:0]     r_rdy2;
    logic [PAYLOAD_W-1:0] r_payload  [DEPTH];
    logic [TAG_W-1:0]     r_dst_tag  [DEPTH];
    logic [TAG_W-1:0]     r_src1_tag [DEPTH];
    logic [TAG_W-1:0]     r_src2_tag [DEPTH];
    logic [IDX_W:0]       r_count;
    logic [0:0]           r_iss_state;
    logic [PAYLOAD_W-1:0] r_iss_payload;
    logic [TAG_W-1:0]     r_iss_dst_tag;

    logic [DEPTH-1:0]     w_req_vec;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_slot_can_load;
    logic                 w_grant_ok;
    logic                 w_disp_ok;
    logic                 w_byp1;
    logic                 w_byp2;

    // Request depends only on registered state, so grant_idx never loops back into req_vec.
    assign w_req_vec       = r_valid & r_rdy1 & r_rdy2;
    assign o_disp_ready    = (r_count != FULL_COUNT);
    assign w_disp_ok       = i_disp_valid & o_disp_ready;
    assign w_slot_can_load = (r_iss_state == S_EMPTY) | i_iss_ready;
    assign w_grant_ok      = i_grant_valid & w_req_vec[i_grant_idx] & w_slot_can_load;
    assign w_byp1          = i_wb_valid & (i_wb_tag == i_disp_src1_tag);
    assign w_byp2          = i_wb_valid & (i_wb_tag == i_disp_src2_tag);

    // NOTE: default assigned before the loop so no path leaves w_free_idx unassigned (no latch).
    always_comb begin
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= '0;
            r_rdy1        <= '0;
            r_rdy2        <= '0;
            r_count       <= '0;
            r_iss_state   <= S_EMPTY;
            r_iss_payload <= '0;
            r_iss_dst_tag <= '0;
        end else if (i_flush) begin
            r_valid     <= '0;
            r_count     <= '0;
            r_iss_state <= S_EMPTY;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && i_wb_valid) begin
                    if (r_src1_tag[i] == i_wb_tag) r_rdy1[i] <= 1'b1;
                    if (r_src2_tag[i] == i_wb_tag) r_rdy2[i] <= 1'b1;
                end
            end
            if (w_grant_ok) r_valid[i_grant_idx] <= 1'b0;
            // The free slot is never valid, so this cannot collide with the grant or wakeup above.
            if (w_disp_ok) begin
                r_valid[w_free_idx] <= 1'b1;
                r_rdy1[w_free_idx]  <= i_disp_src1_rdy | w_byp1;
                r_rdy2[w_free_idx]  <= i_disp_src2_rdy | w_byp2;
            end
            case ({w_disp_ok, w_grant_ok})
                2'b10:   r_count <= r_count + (IDX_W+1)'(1);
                2'b01:   r_count <= r_count - (IDX_W+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_grant_ok) begin
                r_iss_state   <= S_FULL;
                r_iss_payload <= r_payload[i_grant_idx];
                r_iss_dst_tag <= r_dst_tag[i_grant_idx];
            end else if (i_iss_ready) begin
                r_iss_state <= S_EMPTY;
            end
        end
    end

    // NOTE: entry storage is not reset; it is only observed while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_disp_ok) begin
            r_payload[w_free_idx]  <= i_disp_payload;
            r_dst_tag[w_free_idx]  <= i_disp_dst_tag;
            r_src1_tag[w_free_idx] <= i_disp_src1_tag;
            r_src2_tag[w_free_idx] <= i_disp_src2_tag;
        end
    end

    assign o_req_vec     = w_req_vec;
    assign o_iss_valid   = (r_iss_state == S_FULL);
    assign o_iss_payload = r_iss_payload;
    assign o_iss_dst_tag = r_iss_dst_tag;
    assign o_count       = r_count;

    a_grant_requests: assert property (@(posedge clk) disable iff (rst)
        i_grant_valid |-> w_req_vec[i_grant_idx]);

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed vector table, hand-written corner sequences
// and randomized traffic compared against an entry-list reference model.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int TAG_W = 6;
    localparam int PW    = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             dv;
    logic             disp_ready;
    logic [PW-1:0]    dpl;
    logic [TAG_W-1:0] ddst, ds1t, ds2t;
    logic             ds1r, ds2r;
    logic             wbv;
    logic [TAG_W-1:0] wbt;
    logic [DEPTH-1:0] req_vec;
    logic             gv;
    logic [IDX_W-1:0] gi;
    logic             iss_valid;
    logic             ir;
    logic [PW-1:0]    iss_payload;
    logic [TAG_W-1:0] iss_dst;
    logic [IDX_W:0]   count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .i_flush(flush),
        .i_disp_valid(dv), .o_disp_ready(disp_ready), .i_disp_payload(dpl),
        .i_disp_dst_tag(ddst), .i_disp_src1_tag(ds1t), .i_disp_src2_tag(ds2t),
        .i_disp_src1_rdy(ds1r), .i_disp_src2_rdy(ds2r),
        .i_wb_valid(wbv), .i_wb_tag(wbt), .o_req_vec(req_vec),
        .i_grant_valid(gv), .i_grant_idx(gi),
        .o_iss_valid(iss_valid), .i_iss_ready(ir),
        .o_iss_payload(iss_payload), .o_iss_dst_tag(iss_dst), .o_count(count)
    );

    // Reference model: a plain list of entries plus the issue slot.
    bit               m_v  [DEPTH];
    bit               m_r1 [DEPTH];
    bit               m_r2 [DEPTH];
    logic [PW-1:0]    m_pl [DEPTH];
    logic [TAG_W-1:0] m_dst[DEPTH];
    logic [TAG_W-1:0] m_t1 [DEPTH];
    logic [TAG_W-1:0] m_t2 [DEPTH];
    bit               m_iv;
    logic [PW-1:0]    m_ipl;
    logic [TAG_W-1:0] m_idst;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_v[i]);
        return n;
    endfunction

    function automatic logic [DEPTH-1:0] m_req();
        logic [DEPTH-1:0] r = '0;
        for (int i = 0; i < DEPTH; i++) r[i] = m_v[i] && m_r1[i] && m_r2[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
        end
        m_iv = 0; m_ipl = '0; m_idst = '0;
    endtask

    task automatic model_step();
        logic [DEPTH-1:0] req;
        bit take_grant, take_disp;
        int free_slot;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
            m_iv = 0;
            return;
        end
        req        = m_req();
        take_grant = gv && req[gi] && (!m_iv || ir);
        take_disp  = dv && (m_count() < DEPTH);
        free_slot  = -1;
        for (int i = 0; i < DEPTH; i++)
            if (!m_v[i] && free_slot < 0) free_slot = i;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_v[i] && wbv && m_t1[i] == wbt) m_r1[i] = 1;
            if (m_v[i] && wbv && m_t2[i] == wbt) m_r2[i] = 1;
        end
        if (take_grant) begin
            m_ipl = m_pl[gi]; m_idst = m_dst[gi]; m_v[gi] = 0; m_iv = 1;
        end else if (ir) begin
            m_iv = 0;
        end
        if (take_disp) begin
            m_v[free_slot]   = 1;
            m_pl[free_slot]  = dpl;
            m_dst[free_slot] = ddst;
            m_t1[free_slot]  = ds1t;
            m_t2[free_slot]  = ds2t;
            m_r1[free_slot]  = ds1r || (wbv && wbt == ds1t);
            m_r2[free_slot]  = ds2r || (wbv && wbt == ds2t);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ":count"},      64'(count),      64'(m_count()));
        check({tag, ":req_vec"},    64'(req_vec),    64'(m_req()));
        check({tag, ":disp_ready"}, 64'(disp_ready), 64'(m_count() != DEPTH));
        check({tag, ":iss_valid"},  64'(iss_valid),  64'(m_iv));
        if (m_iv) begin
            check({tag, ":iss_payload"}, 64'(iss_payload), 64'(m_ipl));
            check({tag, ":iss_dst"},     64'(iss_dst),     64'(m_idst));
        end
    endtask

    task automatic idle_inputs();
        flush = 0; dv = 0; dpl = '0; ddst = '0; ds1t = '0; ds2t = '0;
        ds1r = 0; ds2r = 0; wbv = 0; wbt = '0; gv = 0; gi = '0; ir = 0;
    endtask

    task automatic set_disp(input logic [PW-1:0] pl, input logic [TAG_W-1:0] dst,
                            input logic [TAG_W-1:0] t1, input logic r1,
                            input logic [TAG_W-1:0] t2, input logic r2);
        dv = 1; dpl = pl; ddst = dst; ds1t = t1; ds1r = r1; ds2t = t2; ds2r = r2;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        check("reset:count",       64'(count),       64'd0);
        check("reset:req_vec",     64'(req_vec),     64'd0);
        check("reset:iss_valid",   64'(iss_valid),   64'd0);
        check("reset:iss_payload", 64'(iss_payload), 64'd0);
        check("reset:iss_dst",     64'(iss_dst),     64'd0);
        check("reset:disp_ready",  64'(disp_ready),  64'd1);
    endtask

    typedef struct {
        logic             dv;
        logic [PW-1:0]    pl;
        logic             gv;
        logic [IDX_W-1:0] gi;
        logic             ir;
        logic [IDX_W:0]   e_cnt;
        logic [DEPTH-1:0] e_req;
        logic             e_iv;
        logic [PW-1:0]    e_ipl;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{1'b1, 32'hA0, 1'b0, 3'd0, 1'b1, 4'd1, 8'h01, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 32'hA1, 1'b0, 3'd0, 1'b1, 4'd2, 8'h03, 1'b0, 32'h0};
        tbl[2] = '{1'b1, 32'hA2, 1'b1, 3'd0, 1'b1, 4'd2, 8'h06, 1'b1, 32'hA0};
        tbl[3] = '{1'b0, 32'h00, 1'b1, 3'd1, 1'b1, 4'd1, 8'h04, 1'b1, 32'hA1};
        tbl[4] = '{1'b0, 32'h00, 1'b1, 3'd2, 1'b1, 4'd0, 8'h00, 1'b1, 32'hA2};
        tbl[5] = '{1'b0, 32'h00, 1'b0, 3'd0, 1'b1, 4'd0, 8'h00, 1'b0, 32'h0};

        rst = 1;
        idle_inputs();
        do_reset();

        // Three ready entries issued back to back.
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            if (tbl[k].dv) set_disp(tbl[k].pl, 6'd1, 6'd2, 1'b1, 6'd3, 1'b1);
            gv = tbl[k].gv; gi = tbl[k].gi; ir = tbl[k].ir;
            tick("table");
            check($sformatf("vec%0d:count", k),   64'(count),     64'(tbl[k].e_cnt));
            check($sformatf("vec%0d:req", k),     64'(req_vec),   64'(tbl[k].e_req));
            check($sformatf("vec%0d:iss_v", k),   64'(iss_valid), 64'(tbl[k].e_iv));
            if (tbl[k].e_iv)
                check($sformatf("vec%0d:iss_pl", k), 64'(iss_payload), 64'(tbl[k].e_ipl));
        end

        // Wakeup two cycles after dispatch.
        do_reset();
        idle_inputs(); set_disp(32'hB0, 6'd9, 6'd5, 1'b0, 6'd1, 1'b1);
        tick("wake_disp");
        check("wake:req_after_disp", 64'(req_vec), 64'h0);
        idle_inputs();
        tick("wake_idle");
        check("wake:req_idle", 64'(req_vec), 64'h0);
        idle_inputs(); wbv = 1; wbt = 6'd5;
        tick("wake_wb");
        check("wake:req_after_wb", 64'(req_vec), 64'h1);
        idle_inputs(); gv = 1; gi = 3'd0; ir = 1;
        tick("wake_grant");
        check("wake:iss_payload", 64'(iss_payload), 64'hB0);
        check("wake:iss_dst",     64'(iss_dst),     64'd9);
        // Same-cycle bypass waking both sources at insert.
        idle_inputs(); set_disp(32'hB1, 6'd10, 6'd5, 1'b0, 6'd5, 1'b0); wbv = 1; wbt = 6'd5; ir = 1;
        tick("bypass");
        check("bypass:req", 64'(req_vec), 64'h1);

        // Fill the queue, then a grant frees slot 3 for the next dispatch.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            idle_inputs(); set_disp(32'hC0 + 32'(i), 6'(i), 6'd0, 1'b1, 6'd0, 1'b1);
            tick("fill");
        end
        check("full:count",      64'(count),      64'd8);
        check("full:disp_ready", 64'(disp_ready), 64'd0);
        idle_inputs(); set_disp(32'hEE, 6'd0, 6'd0, 1'b1, 6'd0, 1'b1);
        tick("full_drop");
        check("full:drop_count", 64'(count), 64'd8);
        idle_inputs(); set_disp(32'hEF, 6'd0, 6'd0, 1'b1, 6'd0, 1'b1);
        gv = 1; gi = 3'd3; ir = 1;
        tick("full_grant");
        check("full_grant:count",      64'(count),       64'd7);
        check("full_grant:iss_pl",     64'(iss_payload), 64'hC3);
        check("full_grant:disp_ready", 64'(disp_ready),  64'd1);
        idle_inputs(); set_disp(32'hD3, 6'd33, 6'd0, 1'b1, 6'd0, 1'b1);
        tick("refill");
        check("refill:count", 64'(count), 64'd8);

        // Stalled issue slot: pulsing grants must be ignored.
        for (int k = 0; k < 4; k++) begin
            idle_inputs(); gv = (k % 2 == 0); gi = 3'd3; ir = 0;
            tick("stall");
            check("stall:count",  64'(count),       64'd8);
            check("stall:iss_pl", 64'(iss_payload), 64'hC3);
            check("stall:req",    64'(req_vec),     64'hFF);
        end
        idle_inputs(); gv = 1; gi = 3'd3; ir = 1;
        tick("slot3");
        check("slot3:iss_pl",  64'(iss_payload), 64'hD3);
        check("slot3:iss_dst", 64'(iss_dst),     64'd33);

        // Flush with five entries, a full slot and concurrent dispatch/grant/wakeup.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle_inputs(); set_disp(32'hF0 + 32'(i), 6'd2, 6'd0, 1'b1, 6'd4, 1'b0);
            if (i < 5) ds2r = 1;
            tick("pre_flush");
        end
        idle_inputs(); gv = 1; gi = 3'd0; ir = 1;
        tick("pre_flush_grant");
        check("pre_flush:count", 64'(count), 64'd5);
        idle_inputs(); flush = 1; set_disp(32'h99, 6'd1, 6'd0, 1'b1, 6'd0, 1'b1);
        gv = 1; gi = 3'd1; ir = 0; wbv = 1; wbt = 6'd4;
        tick("flush");
        check("flush:count",     64'(count),     64'd0);
        check("flush:iss_valid", 64'(iss_valid), 64'd0);
        check("flush:req",       64'(req_vec),   64'd0);

        // Asynchronous reset in the middle of operation.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); set_disp(32'h70 + 32'(i), 6'd3, 6'd0, 1'b1, 6'd0, 1'b1);
            tick("pre_rst");
        end
        idle_inputs(); gv = 1; gi = 3'd1; ir = 0;
        tick("pre_rst_grant");
        idle_inputs();
        #3 rst = 1;
        #1;
        model_reset();
        check("async_rst:count",     64'(count),       64'd0);
        check("async_rst:iss_valid", 64'(iss_valid),   64'd0);
        check("async_rst:iss_pl",    64'(iss_payload), 64'd0);
        check("async_rst:req",       64'(req_vec),     64'd0);
        #3 rst = 0;
        tick("post_rst");

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            logic [DEPTH-1:0] r;
            idle_inputs();
            if ($urandom_range(0, 99) < 60)
                set_disp($urandom(), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 7)),
                         1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            wbv = 1'($urandom_range(0, 1));
            wbt = 6'($urandom_range(0, 7));
            ir  = ($urandom_range(0, 99) < 70);
            r   = m_req();
            if (r != '0 && $urandom_range(0, 99) < 70) begin
                int s = $urandom_range(0, DEPTH - 1);
                while (!r[s]) s = (s + 1) % DEPTH;
                gv = 1; gi = 3'(s);
            end else begin
                gi = 3'($urandom_range(0, DEPTH - 1));
            end
            flush = ($urandom_range(0, 99) < 2);
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
